// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words
// and writes them to IMEM, holding the CPU off until the whole program is in place.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  byte_idx;
  logic [15:0] count_q;
  logic        accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count == 16'd0)
            state_next = DONE;
          else if (word_count <= MAX_W)
            state_next = RECV;
        end
      end
      RECV: begin
        if (accept && byte_idx == 2'd3)
          state_next = WRITE;
      end
      WRITE: begin
        if (words_loaded + 16'd1 == count_q)
          state_next = DONE;
        else
          state_next = RECV;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered yet
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      count_q      <= 16'd0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 32'd0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == RECV);
      mem_we   <= (state_next == WRITE);
      done     <= (state_next == DONE);
      busy     <= (state_next == RECV) || (state_next == WRITE);
      cpu_hold <= (state_next == RECV) || (state_next == WRITE);

      case (state)
        IDLE: begin
          if (start) begin
            if (word_count > MAX_W) begin
              error <= 1'b1;
            end else begin
              error        <= 1'b0;
              words_loaded <= 16'd0;
              byte_idx     <= 2'd0;
              mem_addr     <= BASE_ADDR;
              count_q      <= word_count;
            end
          end
        end
        RECV: begin
          if (accept) begin
            mem_wdata[{byte_idx, 3'b000} +: 8] <= in_data;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          mem_addr     <= mem_addr + 32'd4;
          byte_idx     <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized loads compared
// against a byte-stream reference model of the expected IMEM writes.
module tb_imem_loader;

  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int          MAX_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(.BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observed IMEM writes as {addr, data}, plus protocol event counters.
  logic [63:0] obs_q[$];
  int done_cnt = 0;
  int we_ready_viol = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      obs_q.push_back({mem_addr, mem_wdata});
      if (in_ready) we_ready_viol++;
    end
    if (done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic startLoad(input logic [15:0] count);
    @(negedge clk);
    start      = 1'b1;
    word_count = count;
    @(negedge clk);
    start      = 1'b0;
    word_count = 16'($urandom);
  endtask

  // gap_mode: 0 = valid held high, 1 = valid on alternate cycles, 2 = random valid.
  task automatic sendBytes(input logic [7:0] bytes[$], input int gap_mode,
                           input int glitch_at);
    int   idx = 0;
    int   cycles = 0;
    logic rdy_prev = 1'b0;
    bit   glitched = 1'b0;
    while (idx < bytes.size() && cycles < 4000) begin
      @(negedge clk);
      if (in_valid && rdy_prev) idx++;
      rdy_prev = in_ready;
      start = 1'b0;
      if (glitch_at >= 0 && idx == glitch_at && !glitched) begin
        start      = 1'b1;
        word_count = 16'd1;
        glitched   = 1'b1;
      end
      if (idx < bytes.size()) begin
        in_data = bytes[idx];
        case (gap_mode)
          0:       in_valid = 1'b1;
          1:       in_valid = (cycles % 2) == 0;
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
      end else begin
        in_valid = 1'b0;
      end
      cycles++;
    end
    start = 1'b0;
    checkOutput("bytes_consumed", 32'(idx), 32'(bytes.size()));
  endtask

  task automatic applyStimulus(input logic [15:0] count, input logic [7:0] bytes[$],
                               input int gap_mode, input int glitch_at);
    int  base_w = obs_q.size();
    int  base_d;
    int  base_v = we_ready_viol;
    bit  found = 1'b0;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    startLoad(count);
    base_d = done_cnt;
    checkOutput("cpu_hold_loading", 32'(cpu_hold), 32'd1);
    checkOutput("busy_loading", 32'(busy), 32'd1);
    sendBytes(bytes, gap_mode, glitch_at);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    checkOutput("done_seen", 32'(found), 32'd1);
    checkOutput("cpu_hold_at_done", 32'(cpu_hold), 32'd0);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("words_loaded", 32'(words_loaded), 32'(count));
    checkOutput("final_addr", mem_addr, BASE_ADDR + 32'(4 * int'(count)));
    repeat (2) @(negedge clk);
    #1;
    checkOutput("done_pulses", 32'(done_cnt - base_d), 32'd1);
    checkOutput("write_count", 32'(obs_q.size() - base_w), 32'(count));
    checkOutput("ready_during_write", 32'(we_ready_viol - base_v), 32'd0);
    checkOutput("cpu_hold_after", 32'(cpu_hold), 32'd0);
    // Word w is bytes 4w..4w+3 with the first byte in the low lane.
    for (int w = 0; w < int'(count); w++) begin
      exp_addr = BASE_ADDR + 32'(4 * w);
      exp_data = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
      if (base_w + w < obs_q.size()) begin
        checkOutput($sformatf("addr_w%0d", w), obs_q[base_w+w][63:32], exp_addr);
        checkOutput($sformatf("data_w%0d", w), obs_q[base_w+w][31:0], exp_data);
      end
    end
  endtask

  initial begin
    logic [7:0] bq[$];
    int n_w;
    int base_w;
    int base_d;

    reset = 1'b1; start = 1'b0; word_count = 16'd0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, BASE_ADDR);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_words_loaded", 32'(words_loaded), 32'd0);
    reset = 1'b0;

    $display("[TB] two-word program, valid held high");
    bq = {8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    applyStimulus(16'd2, bq, 0, -1);

    $display("[TB] same program, valid on alternate cycles");
    applyStimulus(16'd2, bq, 1, -1);

    $display("[TB] zero-word load");
    base_w = obs_q.size();
    base_d = done_cnt;
    startLoad(16'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("zero_done_low", 32'(done), 32'd0);
    #1;
    checkOutput("zero_done_pulses", 32'(done_cnt - base_d), 32'd1);
    checkOutput("zero_writes", 32'(obs_q.size() - base_w), 32'd0);

    $display("[TB] oversized load rejected");
    startLoad(16'd65);
    checkOutput("big_error", 32'(error), 32'd1);
    checkOutput("big_busy", 32'(busy), 32'd0);
    checkOutput("big_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("big_error_sticky", 32'(error), 32'd1);
    checkOutput("big_cpu_hold", 32'(cpu_hold), 32'd0);
    bq = {8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(16'd1, bq, 0, -1);
    checkOutput("error_cleared", 32'(error), 32'd0);

    $display("[TB] reset mid-load");
    base_w = obs_q.size();
    startLoad(16'd1);
    bq = {8'h11, 8'h22};
    sendBytes(bq, 0, -1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_addr", mem_addr, BASE_ADDR);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("midrst_writes", 32'(obs_q.size() - base_w), 32'd0);
    bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    applyStimulus(16'd1, bq, 0, -1);

    $display("[TB] start pulsed mid-load");
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
    applyStimulus(16'd3, bq, 2, 5);

    $display("[TB] randomized loads");
    for (int t = 0; t < 5; t++) begin
      n_w = $urandom_range(1, 6);
      bq.delete();
      for (int i = 0; i < 4 * n_w; i++) bq.push_back(8'($urandom));
      applyStimulus(16'(n_w), bq, 2, -1);
    end

    $display("[TB] full-capacity load");
    bq.delete();
    for (int i = 0; i < 4 * MAX_WORDS; i++) bq.push_back(8'($urandom));
    applyStimulus(16'(MAX_WORDS), bq, 0, -1);
    checkOutput("full_error", 32'(error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
